// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch front end.
//   - RESET_PC / ROM_BASE / ROM_LIMIT : default fetch window of the boot ROM.
//   - fetch_entry_t                   : one prefetched word tagged with its PC.
//   - fetch_state_t                   : fetch sequencer states.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
  localparam logic [31:0] ROM_LIMIT = 32'hBFC0_0FFC;

  // PC in the upper half so a packed entry reads as {pc, instr}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry synchronous FIFO of fetch_entry_t used as the prefetch queue.
//   The head entry is presented combinationally from its storage register so
//   that decode sees it in the cycle after it was written.
//
// Ports
//   clk      in   1            clock, rising edge
//   rst      in   1            asynchronous active-high reset, empties the FIFO
//   flush    in   1            synchronous flush; wins over push/pop
//   push     in   1            write wr_data at the tail
//   pop      in   1            discard the head
//   wr_data  in   fetch_entry_t
//   rd_data  out  fetch_entry_t  head entry (stale when count==0)
//   count    out  CNT_W        number of valid entries
//   full     out  1            count == DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  fetch_entry_t     entry_arr [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; the tail slot then equals the head slot, which is read before the
  // edge and overwritten at it.
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop  && !flush && !empty;

  // One storage register per entry; each is written only when the tail
  // pointer selects it. Reset clears the data so the head reads as zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_entry_t entry_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign entry_arr[gi] = entry_reg;
  end

  assign rd_data = entry_arr[rd_ptr_reg];
  assign count   = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule : fetch_fifo

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, drives the combinational
//   ROM address, and pushes {pc, word} into a prefetch FIFO that decode drains
//   with a valid/ready handshake. A redirect flushes the queue and restarts
//   fetch. Leaving the ROM window parks the sequencer in FAULT until the next
//   redirect.
//
// Ports
//   clk          in   1              clock, rising edge
//   rst          in   1              asynchronous active-high reset
//   mem_addr     out  ADDRESS_WIDTH  ROM read address (= fetch PC)
//   mem_rdata    in   DATA_WIDTH     ROM data, combinational from mem_addr
//   instr_valid  out  1              FIFO head is valid
//   instr_ready  in   1              decode accepts the head this cycle
//   instr        out  DATA_WIDTH     head instruction word
//   instr_pc     out  ADDRESS_WIDTH  PC of head instruction
//   redirect     in   1              flush and restart at redirect_pc
//   redirect_pc  in   ADDRESS_WIDTH  restart PC (low two bits ignored)
//   fetch_fault  out  1              sticky: fetch PC left the ROM window
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                          ADDRESS_WIDTH = 32,
  parameter int                          DATA_WIDTH    = 32,
  parameter int                          DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = fetch_pkg::RESET_PC,
  parameter logic [ADDRESS_WIDTH-1:0]    ROM_BASE      = fetch_pkg::ROM_BASE,
  parameter logic [ADDRESS_WIDTH-1:0]    ROM_LIMIT     = fetch_pkg::ROM_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [DATA_WIDTH-1:0]     instr,
  output logic [ADDRESS_WIDTH-1:0]  instr_pc,
  input  logic                      redirect,
  input  logic [ADDRESS_WIDTH-1:0]  redirect_pc,
  output logic                      fetch_fault
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t              state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0]  pc_reg,    pc_next;

  logic                      pc_in_range;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic [CNT_W-1:0]          fifo_count;
  fetch_entry_t              wr_entry;
  fetch_entry_t              rd_entry;

  assign pc_in_range = (pc_reg >= ROM_BASE) && (pc_reg <= ROM_LIMIT);

  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;

  // -------------------------------------------------------------------------
  // Next-state / next-PC. Redirect overrides everything in either state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;

    if (redirect) begin
      state_next = RUN;
      pc_next    = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    end else begin
      case (state_reg)
        RUN: begin
          if (!pc_in_range) begin
            // No fetch from outside the window; the fault is visible from
            // the next cycle and the PC is left pointing at the culprit.
            state_next = FAULT;
          end else if (!fifo_full || pop) begin
            push    = 1'b1;
            pc_next = pc_reg + ADDRESS_WIDTH'(4);
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch queue
  // -------------------------------------------------------------------------
  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc_reg;
    wr_entry.instr = mem_rdata;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign mem_addr    = pc_reg;
  assign instr       = rd_entry.instr;
  assign instr_pc    = rd_entry.pc;
  assign fetch_fault = (state_reg == FAULT);

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. A behavioural ROM answers mem_addr in the
//   same cycle; inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int tests_run;
  int tests_failed;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: first four words 0x11..0x44, everything else tagged with
  // the low half of its address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - 32'hBFC0_0000) >> 2;
    if (idx < 32'd4) return (idx + 32'd1) * 32'h11;
    return {a[15:0], 16'hC0DE};
  endfunction

  assign mem_rdata = rom(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    instr_ready  = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;

    // ---- reset state
    cyc(2);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'hBFC0_0000);

    // ---- 1: stream from reset, one per cycle
    rst         = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
      check("stream_pc", instr_pc, 32'hBFC0_0000 + 32'(4 * k));
      check("stream_instr", instr, 32'(k + 1) * 32'h11);
      $display("[TB] stream pc=%h instr=%h", instr_pc, instr);
      if (k < 3) cyc(1);
    end

    // ---- 2: back-pressure fills the queue, then drain in order
    // head 0xBFC0000C still queued; three more pushes fill it.
    instr_ready = 1'b0;
    cyc(10);
    check("full_valid", {31'd0, instr_valid}, 32'd1);
    check("full_head", instr_pc, 32'hBFC0_000C);
    check("full_mem_addr", mem_addr, 32'hBFC0_001C);
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_pc", instr_pc, 32'hBFC0_000C + 32'(4 * k));
      check("drain_instr", instr, rom(32'hBFC0_000C + 32'(4 * k)));
      $display("[TB] drain pc=%h instr=%h", instr_pc, instr);
      if (k < 4) cyc(1);
    end
    check("steady_mem_addr", mem_addr, 32'hBFC0_002C);

    // ---- 3: redirect while full
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0102;
    cyc(1);
    redirect    = 1'b0;
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_mem_addr", mem_addr, 32'hBFC0_0100);
    cyc(1);
    check("redir_first_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_first_pc", instr_pc, 32'hBFC0_0100);
    check("redir_first_instr", instr, 32'h0100_C0DE);
    $display("[TB] redirect pc=%h instr=%h", instr_pc, instr);

    // ---- 4: run off the end of the ROM window
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0FF8;
    cyc(1);
    redirect    = 1'b0;
    check("edge_flush_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1);
    check("edge_pc0", instr_pc, 32'hBFC0_0FF8);
    check("edge_instr0", instr, 32'h0FF8_C0DE);
    cyc(1);
    check("edge_pc1", instr_pc, 32'hBFC0_0FFC);
    check("edge_fault_pre", {31'd0, fetch_fault}, 32'd0);
    cyc(1);
    check("edge_fault", {31'd0, fetch_fault}, 32'd1);
    check("edge_valid", {31'd0, instr_valid}, 32'd0);
    check("edge_mem_addr", mem_addr, 32'hBFC0_1000);
    $display("[TB] limit fault=%0d addr=%h", fetch_fault, mem_addr);
    cyc(2);
    check("edge_fault_sticky", {31'd0, fetch_fault}, 32'd1);
    check("edge_addr_hold", mem_addr, 32'hBFC0_1000);
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0000;
    cyc(1);
    redirect    = 1'b0;
    check("recover_fault", {31'd0, fetch_fault}, 32'd0);
    check("recover_mem_addr", mem_addr, 32'hBFC0_0000);
    cyc(1);
    check("recover_valid", {31'd0, instr_valid}, 32'd1);
    check("recover_pc", instr_pc, 32'hBFC0_0000);
    check("recover_instr", instr, 32'h11);

    // ---- 5: redirect below the window
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0000;
    cyc(1);
    redirect    = 1'b0;
    check("low_fault_pre", {31'd0, fetch_fault}, 32'd0);
    check("low_mem_addr", mem_addr, 32'h0);
    check("low_valid_pre", {31'd0, instr_valid}, 32'd0);
    cyc(1);
    check("low_fault", {31'd0, fetch_fault}, 32'd1);
    check("low_valid", {31'd0, instr_valid}, 32'd0);
    cyc(3);
    check("low_valid_hold", {31'd0, instr_valid}, 32'd0);
    check("low_addr_hold", mem_addr, 32'h0);
    $display("[TB] low fault=%0d valid=%0d", fetch_fault, instr_valid);

    // ---- 6: async reset with 3 entries queued and fault set
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0FF4;
    cyc(1);
    redirect    = 1'b0;
    cyc(4);
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    check("pre_rst_head", instr_pc, 32'hBFC0_0FF4);
    check("pre_rst_fault", {31'd0, fetch_fault}, 32'd1);
    check("pre_rst_addr", mem_addr, 32'hBFC0_1000);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", {31'd0, instr_valid}, 32'd0);
    check("async_fault", {31'd0, fetch_fault}, 32'd0);
    check("async_mem_addr", mem_addr, 32'hBFC0_0000);
    check("async_instr", instr, 32'd0);
    $display("[TB] async reset valid=%0d fault=%0d addr=%h", instr_valid, fetch_fault, mem_addr);
    cyc(1);
    rst         = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    check("restart_pc", instr_pc, 32'hBFC0_0000);
    check("restart_instr", instr, 32'h11);
    cyc(1);
    check("restart_pc2", instr_pc, 32'hBFC0_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fetch_ctrl
